// File: rtl/block_ram_req_ctrl_pkg.sv
// block_ram_req_ctrl_pkg: shared transaction/state types and default widths
package block_ram_req_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  typedef enum logic {WRITE = 1'b0, READ = 1'b1} txn_t;
  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/block_ram_req_ctrl_if.sv
// block_ram_req_ctrl_if: request, response, clear and RAM-port signals of the controller
interface block_ram_req_ctrl_if
  import block_ram_req_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic req_valid;
  logic req_ready;
  txn_t req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic clr_start;
  logic clr_done;
  logic busy;
  logic ram_en;
  logic ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, clr_start, ram_dout,
    input req_ready, rsp_valid, rsp_data, clr_done, busy, ram_en, ram_we, ram_addr, ram_din
  );
  modport slave (
    input req_valid, req_op, req_addr, req_wdata, rsp_ready, clr_start, ram_dout,
    output req_ready, rsp_valid, rsp_data, clr_done, busy, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/block_ram_rsp_fifo.sv
// block_ram_rsp_fifo: synchronous response FIFO with occupancy count and zeroed output when empty
module block_ram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop;
  assign o_valid = r_count != '0;
  assign w_pop = i_pop && o_valid;
  assign o_dout = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(i_push);
      r_rd <= r_rd + AW'(w_pop);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_pop && r_count == CW'(DEPTH)));
endmodule

// File: rtl/block_ram_req_ctrl.sv
// block_ram_req_ctrl: serialises read/write requests onto a RAM port, queues read data, zero-fills on demand
module block_ram_req_ctrl
  import block_ram_req_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RSP_DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  block_ram_req_ctrl_if.slave bus
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  state_t r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr, r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din;
  logic r_clr_done, r_ram_en, r_ram_we, r_rd_wait;
  logic [CW-1:0] w_count;
  logic [CW:0] w_used;
  logic w_accept, w_rd_issue, w_pop, w_rsp_valid;
  assign w_rd_issue = r_ram_en && !r_ram_we;
  assign w_used = {1'b0, w_count} + (CW+1)'(w_rd_issue) + (CW+1)'(r_rd_wait);
  assign bus.req_ready = r_state == RUN && !bus.clr_start && w_used < (CW+1)'(RSP_DEPTH);
  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_pop = w_rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.clr_done = r_clr_done;
  assign bus.busy = r_state == CLEAR;
  assign bus.ram_en = r_ram_en;
  assign bus.ram_we = r_ram_we;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din = r_ram_din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_clr_addr <= '0;
      r_clr_done <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din <= '0;
      r_rd_wait <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      r_rd_wait <= w_rd_issue;
      if (r_state == CLEAR) begin
        r_ram_en <= r_clr_addr != '0;
        r_ram_we <= r_clr_addr != '0;
        r_ram_addr <= r_clr_addr;
        r_ram_din <= '0;
        r_clr_addr <= r_clr_addr + 1'b1;
        r_state <= (r_clr_addr == '0) ? RUN : CLEAR;
        r_clr_done <= r_clr_addr == '0;
      end else if (bus.clr_start) begin
        r_state <= CLEAR;
        r_ram_en <= 1'b1;
        r_ram_we <= 1'b1;
        r_ram_addr <= '0;
        r_ram_din <= '0;
        r_clr_addr <= ADDR_WIDTH'(1);
      end else begin
        r_ram_en <= w_accept;
        r_ram_we <= w_accept && bus.req_op == WRITE;
        r_ram_addr <= bus.req_addr;
        r_ram_din <= bus.req_wdata;
      end
    end
  end
  block_ram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(r_rd_wait),
    .i_din(bus.ram_dout),
    .i_pop(w_pop),
    .o_valid(w_rsp_valid),
    .o_dout(bus.rsp_data),
    .o_count(w_count)
  );
endmodule

// File: tb/tb_block_ram_req_ctrl.sv
// tb_block_ram_req_ctrl: randomized scoreboard bench with RAM model and request-level reference model
module tb_block_ram_req_ctrl;
  import block_ram_req_ctrl_pkg::*;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NW = 1 << AW;
  localparam int DEPTH = 4;
  typedef struct {logic [DW-1:0] d; int avail;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ram [NW];
  logic [DW-1:0] mdl [NW];
  exp_t expq[$];
  int clr_left = 0;
  logic done_exp = 1'b0;
  logic m_ready, m_valid;
  logic rnd_done;
  block_ram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  block_ram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
      else bus.ram_dout <= ram[bus.ram_addr];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      clr_left = 0;
      done_exp = 1'b0;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_clr_done", 32'(bus.clr_done), 0);
      chk("rst_ram_en", 32'(bus.ram_en), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'(!bus.clr_start));
    end else begin
      m_ready = clr_left == 0 && !bus.clr_start && expq.size() < DEPTH;
      m_valid = expq.size() > 0 && expq[0].avail <= cyc;
      chk("busy", 32'(bus.busy), 32'(clr_left > 0));
      chk("clr_done", 32'(bus.clr_done), 32'(done_exp));
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      if (bus.rsp_valid && m_valid) chk("rsp_data", 32'(bus.rsp_data), 32'(expq[0].d));
      if (bus.rsp_valid && bus.rsp_ready && expq.size() > 0) void'(expq.pop_front());
      if (bus.req_valid && m_ready) begin
        if (bus.req_op == WRITE) mdl[bus.req_addr] = bus.req_wdata;
        else expq.push_back('{d: mdl[bus.req_addr], avail: cyc + 3});
      end
      done_exp = clr_left == 1;
      if (clr_left > 0) clr_left--;
      else if (bus.clr_start) begin
        clr_left = NW;
        for (int i = 0; i < NW; i++) mdl[i] = '0;
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input txn_t op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    logic go = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_wdata = d;
    do begin
      @(negedge clk);
      #1;
      go = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!go && n < 3000);
    checks++;
    if (!go) begin
      errors++;
      $display("FAIL send_timeout: request to %0h not accepted within %0d cycles", a, n);
    end
    bus.req_valid = 1'b0;
  endtask
  task automatic clear();
    bus.clr_start = 1'b1;
    step(1);
    bus.clr_start = 1'b0;
    step(NW + 2);
  endtask
  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 100 && expq.size() > 0; i++) step(1);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", expq.size());
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = WRITE;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.clr_start = 1'b0;
    bus.ram_dout = '0;
    rnd_done = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    clear();
    send(WRITE, 8'h12, 16'hBEEF);
    send(READ, 8'h12, '0);
    step(4);
    for (int i = 0; i < 8; i++) send(WRITE, 8'(i + 32), 16'($urandom));
    bus.rsp_ready = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(READ, 8'(i + 32), '0);
      begin
        step(12);
        bus.rsp_ready = 1'b1;
      end
    join
    drain();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(READ, 8'(i + 32), '0);
    step(3);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(READ, 8'(i + 36), '0);
    drain();
    for (int i = 0; i < NW; i++) send(WRITE, 8'(i), 16'(i + 1));
    send(READ, 8'hFF, '0);
    send(WRITE, 8'h30, 16'hAAAA);
    send(READ, 8'h30, '0);
    clear();
    for (int i = 0; i < 12; i++) send(READ, 8'($urandom_range(0, NW - 1)), '0);
    send(READ, 8'h00, '0);
    send(READ, 8'hFF, '0);
    drain();
    send(WRITE, 8'h12, 16'h5A5A);
    bus.clr_start = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op = READ;
    bus.req_addr = 8'h12;
    step(1);
    bus.clr_start = 1'b0;
    send(READ, 8'h12, '0);
    drain();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(txn_t'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
          if ($urandom_range(0, 3) == 0) step(1);
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        bus.rsp_ready = $urandom_range(0, 3) != 0;
        step(1);
      end
    join
    drain();
    bus.clr_start = 1'b1;
    step(1);
    bus.clr_start = 1'b0;
    step(64);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    send(WRITE, 8'h05, 16'h1234);
    send(READ, 8'h05, '0);
    drain();
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
